// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single write port of a FIFO among NUM_REQ requesters using
//   round-robin arbitration with bounded bursts. A burst ends when the owner
//   marks a word as last, after MAX_BURST accepted words, or when the owner
//   drops its request. Writes are held off while the FIFO is full, so the
//   FIFO never sees a write while full.
//
// Parameters
//   WIDTH      data width of each requester word and of the FIFO
//   NUM_REQ    number of requesters (2..16)
//   MAX_BURST  maximum words accepted per grant (1..255)
//
// Ports
//   clk         write-domain clock, rising edge
//   rst         asynchronous active-high reset
//   req         per-requester request (word valid while high)
//   req_data    packed words, requester i at [i*WIDTH +: WIDTH]
//   req_last    marks requester i's current word as last of its burst
//   gnt         one-hot combinational accept strobe
//   fifo_full   FIFO full flag
//   fifo_wr_en  FIFO write enable (combinational)
//   fifo_wdata  FIFO write data (combinational, 0 outside accept cycles)
//   owner       registered index of the current burst owner
//   busy        registered, high while in BURST
//   stall_cnt   (FIFO_WR_ARB_STATS_EN only) saturating count of cycles in
//               which the owner had a word ready but the FIFO was full
//
// Optional build macro: FIFO_WR_ARB_STATS_EN adds the stall_cnt output.

module fifo_wr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic                       fifo_full,
    output logic                       fifo_wr_en,
    output logic [WIDTH-1:0]           fifo_wdata,
    output logic [$clog2(NUM_REQ)-1:0] owner,
    output logic                       busy
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [15:0]                stall_cnt
`endif
);

    localparam int OW = $clog2(NUM_REQ);
    localparam logic [8:0] MAX_B = 9'(MAX_BURST);

    typedef enum logic {IDLE, BURST} state_t;

    state_t                         state;
    logic [OW-1:0]                  last_owner;
    logic [7:0]                     beat_cnt;

    logic [NUM_REQ-1:0][WIDTH-1:0]  words;
    logic                           accept;
    logic                           last_beat;
    logic [OW-1:0]                  pick;
    logic                           pick_vld;

    assign words = req_data;

    // Word accepted only while the owner presents one and the FIFO has room.
    assign accept     = (state == BURST) && req[owner] && !fifo_full;
    assign fifo_wr_en = accept;
    assign fifo_wdata = accept ? words[owner] : '0;
    // beat_cnt is widened by one bit so the compare cannot wrap.
    assign last_beat  = (({1'b0, beat_cnt} + 9'd1) == MAX_B);

    always_comb begin
        gnt = '0;
        if (accept)
            gnt[owner] = 1'b1;
    end

    // Round-robin pick: first set request after last_owner, wrapping, so the
    // previous owner is searched last.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(last_owner) + i) % NUM_REQ;
            if (!pick_vld && req[idx]) begin
                pick     = OW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(NUM_REQ - 1);
            beat_cnt   <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        owner    <= pick;
                        beat_cnt <= '0;
                        state    <= BURST;
                        busy     <= 1'b1;
                    end
                end
                BURST: begin
                    if (!req[owner]) begin
                        // Requester withdrew: nothing written, burst over.
                        state      <= IDLE;
                        busy       <= 1'b0;
                        last_owner <= owner;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (req_last[owner] || last_beat) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            last_owner <= owner;
                        end
                    end
                    // Full with a pending word: everything holds.
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_cnt <= '0;
        else if ((state == BURST) && req[owner] && fifo_full && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule
